reg_writeback: RTL and testbench

//  Writeback controller: the write-side initiator for the 32x32 register file.

---
 rtl/reg_writeback.sv | 135 +++++++++++++
 tb/tb_reg_writeback.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback controller: merges ALU results (priority) with FIFO-queued load returns onto
// the register file write port and tracks pending loads. Optional macro: REG_WB_BYPASS_EN.
module reg_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [ADDR_W-1:0]        chk_rs1,
    input  logic [ADDR_W-1:0]        chk_rs2,
    output logic                     stall,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    wb_t  sel;
    logic sel_valid;
    logic ld_sel;
    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (fifo_count == '0);
    assign ld_ready   = (fifo_count != CNT_W'(DEPTH));

    // Hazard check reads only registered scoreboard state; x0 never stalls.
    assign stall = ((chk_rs1 != '0) && pending[chk_rs1]) |
                   ((chk_rs2 != '0) && pending[chk_rs2]);

    // Write-port arbitration: ALU first, then FIFO head (then bypass when enabled).
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        ld_sel    = 1'b0;
        pop       = 1'b0;
        push      = ld_valid && ld_ready;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel.rd    = alu_rd;
            sel.data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel       = fifo_mem[rptr];
            ld_sel    = 1'b1;
            pop       = 1'b1;
        end
`ifdef REG_WB_BYPASS_EN
        else if (ld_valid) begin
            sel_valid = 1'b1;
            sel.rd    = ld_rd;
            sel.data  = ld_data;
            ld_sel    = 1'b1;
            push      = 1'b0;
        end
`endif
    end

    // Scoreboard update: a new issue outranks a same-edge clear of the same register.
    always_comb begin
        pending_nxt = pending;
        if (ld_sel) begin
            pending_nxt[sel.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Load-return FIFO storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            pending    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            pending <= pending_nxt;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // x0 writes consume the slot but never reach the register file.
            wr_en <= sel_valid && (sel.rd != '0);
            if (sel_valid && (sel.rd != '0)) begin
                wr_addr <= sel.rd;
                wr_data <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback; also honours REG_WB_BYPASS_EN.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    reg_writeback #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        chk_rs1 = '0; chk_rs2 = '0;

        // 1: reset state
        step(); step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        step();
        check("idle_wr_en", 32'(wr_en), 32'd0);

        // 2: ALU write, one-cycle latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        check("alu_wr_en", 32'(wr_en), 32'd1);
        check("alu_wr_addr", 32'(wr_addr), 32'd5);
        check("alu_wr_data", wr_data, 32'hDEADBEEF);
        step();
        check("alu_wr_en_drop", 32'(wr_en), 32'd0);
        check("alu_addr_hold", 32'(wr_addr), 32'd5);

        // 3: load scoreboard and latency
        issue_valid = 1'b1; issue_rd = 5'd7; chk_rs1 = 5'd7;
        step();
        issue_valid = 1'b0;
        check("ld_stall_rs1", 32'(stall), 32'd1);
        chk_rs1 = 5'd0; chk_rs2 = 5'd7;
        #1 check("ld_stall_rs2", 32'(stall), 32'd1);
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        step();
        ld_valid = 1'b0;
`ifndef REG_WB_BYPASS_EN
        check("ld_queued_wr_en", 32'(wr_en), 32'd0);
        check("ld_queued_count", 32'(fifo_count), 32'd1);
        check("ld_queued_stall", 32'(stall), 32'd1);
        step();
`endif
        check("ld_wr_en", 32'(wr_en), 32'd1);
        check("ld_wr_addr", 32'(wr_addr), 32'd7);
        check("ld_wr_data", wr_data, 32'h1234);
        check("ld_stall_clear", 32'(stall), 32'd0);
        check("ld_count_empty", 32'(fifo_count), 32'd0);
        step();
        check("ld_wr_en_drop", 32'(wr_en), 32'd0);
        chk_rs1 = 5'd0;

        // 4: fill FIFO behind a held ALU, then drain in order
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA0000;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'(256 + i);
            step();
            check("fill_alu_wr", 32'(wr_addr), 32'd1);
            if (i == 3) begin
                check("full_count", 32'(fifo_count), 32'd4);
                check("full_ld_ready", 32'(ld_ready), 32'd0);
            end
        end
        ld_valid = 1'b0;
        check("full_count_after5", 32'(fifo_count), 32'd4);
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_wr_en", 32'(wr_en), 32'd1);
            check("drain_wr_addr", 32'(wr_addr), 32'(10 + i));
            check("drain_wr_data", wr_data, 32'(256 + i));
        end
        check("drain_count", 32'(fifo_count), 32'd0);
        step();
        check("drain_idle", 32'(wr_en), 32'd0);

        // 5: x0 rules plus simultaneous push/pop
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h20;
        step();
        issue_valid = 1'b0;
        check("x0_wr_en", 32'(wr_en), 32'd0);
        check("x0_stall", 32'(stall), 32'd0);
        check("pp_count1", 32'(fifo_count), 32'd1);
        alu_valid = 1'b0; ld_rd = 5'd21; ld_data = 32'h21;
        step();
        ld_valid = 1'b0;
        check("pp_count_same", 32'(fifo_count), 32'd1);
        check("pp_wr_addr", 32'(wr_addr), 32'd20);
        step();
        check("pp_wr_addr2", 32'(wr_addr), 32'd21);
        check("pp_count0", 32'(fifo_count), 32'd0);
        step();

        // 6: reset mid-operation drops queue and scoreboard
        alu_valid = 1'b1; alu_rd = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd3; chk_rs1 = 5'd3;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        step();
        issue_valid = 1'b0; ld_rd = 5'd4; ld_data = 32'h44;
        step();
        ld_valid = 1'b0;
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        check("pre_rst_stall", 32'(stall), 32'd1);
        alu_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_wr", 32'(wr_en), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
